// File: rtl/burst_rd_checker.sv
// Avalon-MM read burst checker.
// Queued compare commands describe each expected burst: word address, partial
// first/last word offsets, length, and fixed or LFSR-generated data. Returned
// beats are compared byte-wise in a two-stage pipeline that feeds saturating
// statistics and a first-error capture. A command keeps its queue slot until
// its last beat has been checked, so the queue depth covers active plus
// pending bursts.
module burst_rd_checker #(
  parameter int AMM_DATA_W  = 512,
  parameter int AMM_BURST_W = 11,
  parameter int CMP_ADDR_W  = 26,
  parameter int CMD_DEPTH   = 8,
  parameter int CNT_W       = 32,
  localparam int DATA_B_W   = AMM_DATA_W / 8,
  localparam int ADDR_B_W   = $clog2(DATA_B_W)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clr_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [CMP_ADDR_W-1:0]          cmd_addr_i,
  input  logic [ADDR_B_W-1:0]            cmd_start_off_i,
  input  logic [ADDR_B_W-1:0]            cmd_end_off_i,
  input  logic [AMM_BURST_W-2:0]         cmd_words_i,
  input  logic                           cmd_rnd_i,
  input  logic [7:0]                     cmd_ptrn_i,
  input  logic                           rdvalid_i,
  input  logic [AMM_DATA_W-1:0]          rddata_i,
  output logic                           busy_o,
  output logic                           err_o,
  output logic [CMP_ADDR_W+ADDR_B_W-1:0] err_addr_o,
  output logic [7:0]                     err_data_o,
  output logic [CNT_W-1:0]               err_cnt_o,
  output logic [CNT_W-1:0]               bytes_cnt_o,
  output logic [CNT_W-1:0]               words_cnt_o,
  output logic                           orphan_o
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam logic [PTR_W:0]           DEPTH_C  = (PTR_W+1)'(CMD_DEPTH);
  localparam logic [PTR_W:0]           TWO_C    = (PTR_W+1)'(2);
  localparam logic [PTR_W:0]           CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0]         PTR_ONE  = PTR_W'(1);
  localparam logic [CMP_ADDR_W-1:0]    ADDR_ONE = CMP_ADDR_W'(1);
  localparam logic [AMM_BURST_W-2:0]   WCNT_ONE = (AMM_BURST_W-1)'(1);
  localparam logic [CNT_W-1:0]         STAT_ONE = CNT_W'(1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_CHECK = 1'b1} state_t;

  typedef struct packed {
    logic [CMP_ADDR_W-1:0]  addr;
    logic [ADDR_B_W-1:0]    start_off;
    logic [ADDR_B_W-1:0]    end_off;
    logic [AMM_BURST_W-2:0] words;
    logic                   rnd;
    logic [7:0]             ptrn;
  } cmd_t;

  // Galois LFSR, x^8+x^6+x^5+x^4+1, shifting towards the MSB.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h71 : 8'h00);
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced.
  function automatic logic [7:0] lfsr_seed(input logic [7:0] p);
    return (p == 8'h00) ? 8'hFF : p;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [DATA_B_W-1:0] v);
    logic [CNT_W-1:0] sum;
    sum = {CNT_W{1'b0}};
    for (int i = 0; i < DATA_B_W; i++) sum = sum + {{(CNT_W-1){1'b0}}, v[i]};
    return sum;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  cmd_t                    queue_mem [CMD_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]          count_r;
  state_t                  state_r;
  logic [CMP_ADDR_W-1:0]   cur_addr_r;
  logic [AMM_BURST_W-2:0]  wcnt_r;
  logic [7:0]              lfsr_r;
  logic                    first_r;

  logic                    s1_beat_r, s1_orphan_r;
  logic [DATA_B_W-1:0]     s1_mask_r, s1_mis_r;
  logic [CMP_ADDR_W-1:0]   s1_addr_r;
  logic [ADDR_B_W-1:0]     s1_idx_r;
  logic [7:0]              s1_byte_r;

  cmd_t                    head_s, next_s;
  logic [PTR_W-1:0]        rd_ptr_inc_s;
  logic                    push_s, use_head_s, beat_ok_s, last_s, retire_s, orphan_beat_s;
  logic [CMP_ADDR_W-1:0]   eff_addr_s;
  logic [AMM_BURST_W-2:0]  eff_wcnt_s;
  logic [7:0]              eff_lfsr_s, exp_s, first_byte_s;
  logic                    eff_first_s;
  logic [DATA_B_W-1:0]     mask_s, mis_s;
  logic [ADDR_B_W-1:0]     first_idx_s;

  // Active-burst view, per-byte mask and mismatch vector for the current beat.
  always_comb begin
    rd_ptr_inc_s  = rd_ptr_r + PTR_ONE;
    head_s        = queue_mem[rd_ptr_r];
    next_s        = queue_mem[rd_ptr_inc_s];
    push_s        = cmd_valid_i && (count_r != DEPTH_C);
    use_head_s    = (state_r == ST_IDLE) && (count_r != '0);
    eff_addr_s    = use_head_s ? head_s.addr : cur_addr_r;
    eff_wcnt_s    = use_head_s ? head_s.words : wcnt_r;
    eff_lfsr_s    = use_head_s ? lfsr_seed(head_s.ptrn) : lfsr_r;
    eff_first_s   = use_head_s ? 1'b1 : first_r;
    beat_ok_s     = rdvalid_i && ((state_r == ST_CHECK) || use_head_s);
    last_s        = (eff_wcnt_s == '0);
    retire_s      = beat_ok_s && last_s;
    orphan_beat_s = rdvalid_i && (state_r == ST_IDLE) && (count_r == '0);
    mask_s        = {DATA_B_W{1'b0}};
    mis_s         = {DATA_B_W{1'b0}};
    exp_s         = 8'h00;
    first_idx_s   = {ADDR_B_W{1'b0}};
    first_byte_s  = 8'h00;
    for (int i = 0; i < DATA_B_W; i++) begin
      mask_s[i] = beat_ok_s
                  && (!eff_first_s || (ADDR_B_W'(i) >= head_s.start_off))
                  && (!last_s || (ADDR_B_W'(i) <= head_s.end_off));
      exp_s     = head_s.rnd ? (eff_lfsr_s ^ 8'(i)) : head_s.ptrn;
      mis_s[i]  = mask_s[i] && (rddata_i[i*8 +: 8] != exp_s);
    end
    for (int i = DATA_B_W - 1; i >= 0; i--) begin
      first_idx_s  = mis_s[i] ? ADDR_B_W'(i) : first_idx_s;
      first_byte_s = mis_s[i] ? rddata_i[i*8 +: 8] : first_byte_s;
    end
  end

  // Command storage; entries are only meaningful while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (push_s) queue_mem[wr_ptr_r] <= '{cmd_addr_i, cmd_start_off_i, cmd_end_off_i,
                                         cmd_words_i, cmd_rnd_i, cmd_ptrn_i};
  end

  // Queue pointers and occupancy; a slot is freed when its last beat is checked.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (clr_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s)   wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (retire_s) rd_ptr_r <= rd_ptr_inc_s;
      case ({push_s, retire_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Burst FSM: load the head command, step address/length/LFSR per beat,
  // and chain straight into the next queued command on the last beat.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= ST_IDLE;
      cur_addr_r <= '0;
      wcnt_r     <= '0;
      lfsr_r     <= 8'h00;
      first_r    <= 1'b0;
    end else if (clr_i) begin
      state_r    <= ST_IDLE;
      cur_addr_r <= '0;
      wcnt_r     <= '0;
      lfsr_r     <= 8'h00;
      first_r    <= 1'b0;
    end else begin
      if (use_head_s) begin
        state_r    <= ST_CHECK;
        cur_addr_r <= head_s.addr;
        wcnt_r     <= head_s.words;
        lfsr_r     <= lfsr_seed(head_s.ptrn);
        first_r    <= 1'b1;
      end
      if (beat_ok_s && !last_s) begin
        state_r    <= ST_CHECK;
        cur_addr_r <= eff_addr_s + ADDR_ONE;
        wcnt_r     <= eff_wcnt_s - WCNT_ONE;
        lfsr_r     <= lfsr_step(eff_lfsr_s);
        first_r    <= 1'b0;
      end
      if (retire_s) begin
        if (count_r >= TWO_C) begin
          state_r    <= ST_CHECK;
          cur_addr_r <= next_s.addr;
          wcnt_r     <= next_s.words;
          lfsr_r     <= lfsr_seed(next_s.ptrn);
          first_r    <= 1'b1;
        end else begin
          state_r <= ST_IDLE;
        end
      end
    end
  end

  // Stage 1: capture compare results and the beat address.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_beat_r <= 1'b0; s1_orphan_r <= 1'b0; s1_mask_r <= '0; s1_mis_r <= '0;
      s1_addr_r <= '0;   s1_idx_r <= '0;      s1_byte_r <= 8'h00;
    end else if (clr_i) begin
      s1_beat_r <= 1'b0; s1_orphan_r <= 1'b0; s1_mask_r <= '0; s1_mis_r <= '0;
      s1_addr_r <= '0;   s1_idx_r <= '0;      s1_byte_r <= 8'h00;
    end else begin
      s1_beat_r   <= rdvalid_i;
      s1_orphan_r <= orphan_beat_s;
      s1_mask_r   <= mask_s;
      s1_mis_r    <= mis_s;
      s1_addr_r   <= eff_addr_s;
      s1_idx_r    <= first_idx_s;
      s1_byte_r   <= first_byte_s;
    end
  end

  // Stage 2: statistics and first-error capture, frozen after the first hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      words_cnt_o <= '0; bytes_cnt_o <= '0; err_cnt_o <= '0; orphan_o <= 1'b0;
      err_o <= 1'b0;     err_addr_o <= '0;  err_data_o <= 8'h00;
    end else if (clr_i) begin
      words_cnt_o <= '0; bytes_cnt_o <= '0; err_cnt_o <= '0; orphan_o <= 1'b0;
      err_o <= 1'b0;     err_addr_o <= '0;  err_data_o <= 8'h00;
    end else begin
      if (s1_beat_r) words_cnt_o <= sat_add(words_cnt_o, STAT_ONE);
      bytes_cnt_o <= sat_add(bytes_cnt_o, popcount(s1_mask_r));
      err_cnt_o   <= sat_add(err_cnt_o, popcount(s1_mis_r));
      if (s1_orphan_r) orphan_o <= 1'b1;
      if (!err_o && (s1_mis_r != '0)) begin
        err_o      <= 1'b1;
        err_addr_o <= {s1_addr_r, s1_idx_r};
        err_data_o <= s1_byte_r;
      end
    end
  end

  assign cmd_ready_o = (count_r != DEPTH_C);
  assign busy_o      = (count_r != '0);

endmodule

// File: tb/tb_burst_rd_checker.sv
// Scoreboard bench for burst_rd_checker: directed bursts with hand-computed
// expected statistics, checked by an independent monitor process.
module tb_burst_rd_checker;
  localparam int DW = 512;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0, clr_i = 1'b0;
  logic          cmd_valid_i = 1'b0, cmd_ready_o;
  logic [25:0]   cmd_addr_i = '0;
  logic [5:0]    cmd_start_off_i = '0, cmd_end_off_i = '0;
  logic [9:0]    cmd_words_i = '0;
  logic          cmd_rnd_i = 1'b0;
  logic [7:0]    cmd_ptrn_i = 8'h00;
  logic          rdvalid_i = 1'b0;
  logic [DW-1:0] rddata_i = '0;
  logic          busy_o, err_o, orphan_o;
  logic [31:0]   err_addr_o, err_cnt_o, bytes_cnt_o, words_cnt_o;
  logic [7:0]    err_data_o;

  burst_rd_checker dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_start_off_i(cmd_start_off_i), .cmd_end_off_i(cmd_end_off_i),
    .cmd_words_i(cmd_words_i), .cmd_rnd_i(cmd_rnd_i), .cmd_ptrn_i(cmd_ptrn_i),
    .rdvalid_i(rdvalid_i), .rddata_i(rddata_i), .busy_o(busy_o), .err_o(err_o),
    .err_addr_o(err_addr_o), .err_data_o(err_data_o), .err_cnt_o(err_cnt_o),
    .bytes_cnt_o(bytes_cnt_o), .words_cnt_o(words_cnt_o), .orphan_o(orphan_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic        busy, ready, err, orphan;
    logic [31:0] eaddr;
    logic [7:0]  edata;
    logic [31:0] ecnt, bytes, words;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  logic chk_req = 1'b0;

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    logic [DW-1:0] v;
    for (int i = 0; i < NB; i++) v[i*8 +: 8] = b;
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd_beat(input logic [7:0] l);
    logic [DW-1:0] v;
    for (int i = 0; i < NB; i++) v[i*8 +: 8] = l ^ 8'(i);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_pulse();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  task automatic push_cmd(input logic [25:0] a, input logic [5:0] so, input logic [5:0] eo,
                          input logic [9:0] w, input logic r, input logic [7:0] p);
    cmd_addr_i = a; cmd_start_off_i = so; cmd_end_off_i = eo;
    cmd_words_i = w; cmd_rnd_i = r; cmd_ptrn_i = p;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d);
    rdvalid_i = 1'b1;
    rddata_i  = d;
    tick();
    rdvalid_i = 1'b0;
  endtask

  task automatic expect_out(input int tag, input logic busy, input logic ready,
                            input logic err, input logic orphan, input logic [31:0] eaddr,
                            input logic [7:0] edata, input logic [31:0] ecnt,
                            input logic [31:0] bytes, input logic [31:0] words);
    exp_t e;
    e.tag = tag; e.busy = busy; e.ready = ready; e.err = err; e.orphan = orphan;
    e.eaddr = eaddr; e.edata = edata; e.ecnt = ecnt; e.bytes = bytes; e.words = words;
    expq.push_back(e);
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  task automatic cmp(input int tag, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL chk%0d.%s: got 0x%0h want 0x%0h", tag, nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a check point is presented.
  always @(negedge clk) begin
    if (chk_req) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty: got 0 entries want >=1");
      end else begin
        mon_e = expq.pop_front();
        cmp(mon_e.tag, "busy",      {31'd0, busy_o},      {31'd0, mon_e.busy});
        cmp(mon_e.tag, "cmd_ready", {31'd0, cmd_ready_o}, {31'd0, mon_e.ready});
        cmp(mon_e.tag, "err",       {31'd0, err_o},       {31'd0, mon_e.err});
        cmp(mon_e.tag, "orphan",    {31'd0, orphan_o},    {31'd0, mon_e.orphan});
        cmp(mon_e.tag, "err_addr",  err_addr_o,           mon_e.eaddr);
        cmp(mon_e.tag, "err_data",  {24'd0, err_data_o},  {24'd0, mon_e.edata});
        cmp(mon_e.tag, "err_cnt",   err_cnt_o,            mon_e.ecnt);
        cmp(mon_e.tag, "bytes_cnt", bytes_cnt_o,          mon_e.bytes);
        cmp(mon_e.tag, "words_cnt", words_cnt_o,          mon_e.words);
      end
    end
  end

  initial begin : stim
    logic [DW-1:0] d;
    idle(2);
    rst_i = 1'b1;
    tick();
    expect_out(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 32'd0, 32'd0, 32'd0);

    // Fixed pattern, 4-beat full-word burst.
    clr_pulse();
    push_cmd(26'h10, 6'd0, 6'd63, 10'd3, 1'b0, 8'hA5);
    expect_out(1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 32'd0, 32'd0, 32'd0);
    for (int k = 0; k < 4; k++) beat(fill(8'hA5));
    idle(1);
    expect_out(2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 32'd0, 32'd256, 32'd4);

    // Partial burst: corruption outside the mask is ignored.
    clr_pulse();
    push_cmd(26'h10, 6'd5, 6'd2, 10'd1, 1'b0, 8'hA5);
    d = fill(8'hA5); d[4*8 +: 8] = 8'h00;
    beat(d);
    beat(fill(8'hA5));
    idle(1);
    expect_out(3, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 32'd0, 32'd62, 32'd2);

    // Partial burst: corruption inside the mask is captured.
    clr_pulse();
    push_cmd(26'h10, 6'd5, 6'd2, 10'd1, 1'b0, 8'hA5);
    d = fill(8'hA5); d[6*8 +: 8] = 8'h3C;
    beat(d);
    d = fill(8'hA5); d[10*8 +: 8] = 8'h00;
    beat(d);
    idle(1);
    expect_out(4, 1'b0, 1'b1, 1'b1, 1'b0, 32'h406, 8'h3C, 32'd1, 32'd62, 32'd2);

    // Random mode, zero seed, three back-to-back single-beat bursts.
    clr_pulse();
    for (int k = 0; k < 3; k++) push_cmd(26'(32 + k), 6'd0, 6'd63, 10'd0, 1'b1, 8'h00);
    for (int k = 0; k < 3; k++) beat(rnd_beat(8'hFF));
    idle(1);
    expect_out(5, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 32'd0, 32'd192, 32'd3);

    clr_pulse();
    for (int k = 0; k < 3; k++) push_cmd(26'(32 + k), 6'd0, 6'd63, 10'd0, 1'b1, 8'h00);
    beat(rnd_beat(8'hFF));
    beat(rnd_beat(8'hFF));
    d = rnd_beat(8'hFF); d[7*8 +: 8] = 8'hF9;
    beat(d);
    idle(1);
    expect_out(6, 1'b0, 1'b1, 1'b1, 1'b0, 32'h887, 8'hF9, 32'd1, 32'd192, 32'd3);

    // Random mode, 3 beats: LFSR C3 -> F7 -> 9F, two bad bytes in beat 1.
    clr_pulse();
    push_cmd(26'h30, 6'd0, 6'd63, 10'd2, 1'b1, 8'hC3);
    beat(rnd_beat(8'hC3));
    d = rnd_beat(8'hF7); d[1*8 +: 8] = 8'h00; d[2*8 +: 8] = 8'h00;
    beat(d);
    beat(rnd_beat(8'h9F));
    idle(1);
    expect_out(7, 1'b0, 1'b1, 1'b1, 1'b0, 32'hC41, 8'h00, 32'd2, 32'd192, 32'd3);

    // Queue full: eight pushes fill it, a ninth is dropped.
    clr_pulse();
    for (int k = 0; k < 8; k++) push_cmd(26'(64 + k), 6'd0, 6'd63, 10'd0, 1'b0, 8'(16 + k));
    expect_out(8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 32'd0, 32'd0, 32'd0);
    push_cmd(26'h7F, 6'd0, 6'd63, 10'd0, 1'b0, 8'hEE);
    for (int k = 0; k < 8; k++) beat(fill(8'(16 + k)));
    idle(1);
    expect_out(9, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 32'd0, 32'd512, 32'd8);

    // Orphan beat, then clear colliding with a beat.
    clr_pulse();
    beat(fill(8'h00));
    idle(1);
    expect_out(10, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 8'h00, 32'd0, 32'd0, 32'd1);
    clr_i = 1'b1; rdvalid_i = 1'b1; rddata_i = fill(8'h00);
    tick();
    clr_i = 1'b0; rdvalid_i = 1'b0;
    idle(1);
    expect_out(11, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 32'd0, 32'd0, 32'd0);

    // Reset mid-burst with a bad beat in flight, then a clean burst.
    clr_pulse();
    push_cmd(26'h50, 6'd0, 6'd63, 10'd3, 1'b0, 8'hA5);
    beat(fill(8'hA5));
    d = fill(8'hA5); d[7:0] = 8'h00;
    beat(d);
    rst_i = 1'b0;
    expect_out(12, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 32'd0, 32'd0, 32'd0);
    rst_i = 1'b1;
    idle(2);
    expect_out(13, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 32'd0, 32'd0, 32'd0);
    push_cmd(26'h60, 6'd0, 6'd63, 10'd1, 1'b0, 8'h5A);
    beat(fill(8'h5A));
    beat(fill(8'h5A));
    idle(1);
    expect_out(14, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 8'h00, 32'd0, 32'd128, 32'd2);

    for (int i = 0; i < 10 && expq.size() != 0; i++) tick();
    if (expq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
